// File: rtl/um_pkg.sv
// Shared constants and the write-back entry type for the write-back queue.
package um_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // One pending register-file write: destination register plus result value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo_core.sv
// In-order storage for pending write-backs: entry array, read/write pointers
// and occupancy count. The whole array is exported so the parent can search it.
module wb_fifo_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [ADDR_W-1:0]              push_addr_i,
  input  logic [DATA_W-1:0]              push_data_i,
  input  logic                           pop_i,
  output logic [CNT_W-1:0]               count_o,
  output logic                           full_o,
  output logic [PTR_W-1:0]               rd_ptr_o,
  output logic [ADDR_W-1:0]              head_addr_o,
  output logic [DATA_W-1:0]              head_data_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr_o,
  output logic [DEPTH-1:0][DATA_W-1:0]   ent_data_o
);

  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_mem_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem_q;

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Control state register; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Per-entry storage; data is never cleared, validity comes from the pointers.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_i && (wr_ptr_q == PTR_W'(gi))) begin
        addr_mem_q[gi] <= push_addr_i;
        data_mem_q[gi] <= push_data_i;
      end
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign rd_ptr_o    = rd_ptr_q;
  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign ent_addr_o  = addr_mem_q;
  assign ent_data_o  = data_mem_q;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers execute results in order, drains one per cycle
// into the register file, and forwards in-flight values to decode.
module wb_queue
  import um_pkg::*;
#(
  parameter int DATA_W = um_pkg::DATA_W,
  parameter int ADDR_W = um_pkg::ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count
);

  logic                         push;
  logic                         pop;
  logic                         full;
  logic [CNT_W-1:0]             count_q;
  logic [PTR_W-1:0]             rd_ptr;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PTR_W-1:0]             idx;

  // Handshake: ready depends only on occupancy, so producers never wait on rf_ready.
  assign in_ready = !full && !reset;
  // Writes to register 0 complete the handshake but are dropped here.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign rf_we    = (count_q != '0) && !reset;
  assign pop      = rf_we && rf_ready;
  assign count    = reset ? '0 : count_q;

  wb_fifo_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_addr_i(in_addr),
    .push_data_i(in_data),
    .pop_i      (pop),
    .count_o    (count_q),
    .full_o     (full),
    .rd_ptr_o   (rd_ptr),
    .head_addr_o(rf_waddr),
    .head_data_o(rf_wdata),
    .ent_addr_o (ent_addr),
    .ent_data_o (ent_data)
  );

  // Forwarding search from oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (!reset && (fwd_addr != '0) && (CNT_W'(k) < count_q) &&
          (ent_addr[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: stimulus pushes expected writes into a
// scoreboard queue, a monitor pops and compares every register-file write.
module tb_wb_queue;
  import um_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  wb_entry_t exp_q[$];

  always #5 clk = ~clk;

  wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr (in_addr),
    .in_data (in_data),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .rf_ready(rf_ready),
    .fwd_addr(fwd_addr),
    .fwd_hit (fwd_hit),
    .fwd_data(fwd_data),
    .count   (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  // Offer one result for one cycle; expected writes are queued only when accepted to a real register.
  task automatic offer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic exp_acc);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(exp_acc));
    if (exp_acc && a != '0) begin
      exp_q.push_back('{addr: a, data: d});
    end
    $display("offer addr=%0d data=0x%0h accept=%0d", a, d, exp_acc);
    to_edge();
    in_valid = 1'b0;
  endtask

  // Monitor: every write accepted by the register file must match the scoreboard head.
  initial begin
    wb_entry_t e;
    forever begin
      @(negedge clk);
      if (rf_we && rf_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none", rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 32'(rf_waddr), 32'(e.addr));
          check("wb_data", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit drained;
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_ready = 1'b0; fwd_addr = '0;

    // Reset held for two cycles
    to_edge();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_count", 32'(count), 0);
    to_edge();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);
    check("post_rst_count", 32'(count), 0);
    to_edge();

    // Single pass with one-cycle latency
    rf_ready = 1'b1;
    offer(5'd3, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("single_rf_we", 32'(rf_we), 1);
    check("single_waddr", 32'(rf_waddr), 3);
    to_edge();
    @(negedge clk);
    check("single_rf_we_after", 32'(rf_we), 0);
    to_edge();

    // Fill under backpressure, then drain in order
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) offer(ADDR_W'(i), DATA_W'(i * 'h11), 1'b1);
    @(negedge clk);
    check("full_count", 32'(count), 4);
    check("full_in_ready", 32'(in_ready), 0);
    to_edge();
    offer(5'd5, 32'h55, 1'b0);
    rf_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("drain_waddr", 32'(rf_waddr), 32'(k));
      to_edge();
    end
    @(negedge clk);
    check("drain_empty_we", 32'(rf_we), 0);
    to_edge();

    // Forwarding: youngest of two matches wins
    rf_ready = 1'b0;
    offer(5'd7, 32'hA, 1'b1);
    offer(5'd7, 32'hB, 1'b1);
    fwd_addr = 5'd7;
    @(negedge clk);
    check("fwd_hit2", 32'(fwd_hit), 1);
    check("fwd_data2", fwd_data, 32'hB);
    fwd_addr = 5'd0; #1;
    check("fwd_r0_hit", 32'(fwd_hit), 0);
    fwd_addr = 5'd12; #1;
    check("fwd_miss_hit", 32'(fwd_hit), 0);
    check("fwd_miss_data", fwd_data, 0);
    fwd_addr = 5'd7;
    to_edge();
    rf_ready = 1'b1;
    to_edge();
    rf_ready = 1'b0;
    @(negedge clk);
    check("fwd_hit1", 32'(fwd_hit), 1);
    check("fwd_data1", fwd_data, 32'hB);
    check("fwd_count1", 32'(count), 1);
    to_edge();
    rf_ready = 1'b1;
    to_edge();
    rf_ready = 1'b0;
    @(negedge clk);
    check("fwd_hit0", 32'(fwd_hit), 0);
    check("fwd_data0", fwd_data, 0);
    to_edge();

    // Register 0 is accepted but discarded
    offer(5'd0, 32'hFFFF, 1'b1);
    @(negedge clk);
    check("r0_count", 32'(count), 0);
    check("r0_rf_we", 32'(rf_we), 0);
    to_edge();

    // Simultaneous push and pop keeps count
    offer(5'd8, 32'h1, 1'b1);
    offer(5'd10, 32'h2, 1'b1);
    rf_ready = 1'b1;
    offer(5'd9, 32'h5, 1'b1);
    rf_ready = 1'b0;
    check("pushpop_count", 32'(count), 2);

    // Ten push/pop pairs wrap the pointers
    rf_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(ADDR_W'(16 + i), DATA_W'(32'h100 + i), 1'b1);
      check("wrap_count", 32'(count), 2);
    end
    drained = 1'b0;
    for (int c = 0; c < 10 && !drained; c++) begin
      @(negedge clk);
      if (count == 0) drained = 1'b1;
      to_edge();
    end
    check("wrap_drained", 32'(drained), 1);
    rf_ready = 1'b0;

    // Reset mid-operation discards pending writes
    offer(5'd20, 32'h20, 1'b1);
    offer(5'd21, 32'h21, 1'b1);
    offer(5'd22, 32'h22, 1'b1);
    check("pre_rst_count", 32'(count), 3);
    reset = 1'b1;
    fwd_addr = 5'd21;
    @(negedge clk);
    check("midrst_rf_we", 32'(rf_we), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_fwd_hit", 32'(fwd_hit), 0);
    check("midrst_fwd_data", fwd_data, 0);
    exp_q.delete();
    to_edge();
    reset = 1'b0;
    rf_ready = 1'b1;
    @(negedge clk);
    check("after_rst_count", 32'(count), 0);
    check("after_rst_rf_we", 32'(rf_we), 0);
    check("after_rst_fwd_hit", 32'(fwd_hit), 0);
    to_edge();
    to_edge();
    to_edge();
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
